m_phy_tx_burst_ctrl: RTL

// Burst scheduler for the Type-1 M-PHY-TX state machine. Accepts PWM/HS burst requests, drives line_state and SM strobes.

---
 rtl/m_phy_pkg.sv | 42 ++++
 rtl/m_phy_wait_timer.sv | 37 +++
 rtl/m_phy_tx_burst_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_phy_pkg.sv
// Shared encodings for the M-PHY TX burst controller: line levels, SM state codes,
// controller state and mode-change sub-phases.
package m_phy_pkg;

    localparam logic [1:0] DIF_N = 2'd0;
    localparam logic [1:0] DIF_P = 2'd1;
    localparam logic [1:0] DIF_Q = 2'd2;
    localparam logic [1:0] DIF_Z = 2'd3;

    localparam logic [1:0] PS_OTHER = 2'b00;
    localparam logic [1:0] PS_PWM   = 2'b01;
    localparam logic [1:0] PS_CFG   = 2'b10;
    localparam logic [1:0] PS_HS    = 2'b11;

    typedef enum logic [3:0] {
        StHib,
        StActivate,
        StIdle,
        StCfgExit,
        StCfgEnter,
        StPrepare,
        StConfirm,
        StBurst,
        StExit,
        StPark,
        StHibEnter,
        StError
    } ctrl_state_e;

    // CFG_EXIT walks Prep->Wait->Strobe; CFG_ENTER walks Wait->Strobe->Settle.
    typedef enum logic [1:0] {
        PhPrep,
        PhWait,
        PhStrobe,
        PhSettle
    } cfg_phase_e;

    function automatic logic [1:0] burst_code(input logic hs);
        return hs ? PS_HS : PS_PWM;
    endfunction

endpackage

// File: rtl/m_phy_wait_timer.sv
// Shared cycle counter: cleared on each state/phase entry, flags terminal count and
// wait timeout.
module m_phy_wait_timer #(
    parameter int unsigned Timeout = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] term_i,
    output logic        tc_o,
    output logic        timeout_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = (cnt_q == term_i);
    assign timeout_o = (cnt_q >= 32'(Timeout - 1));

endmodule

// File: rtl/m_phy_tx_burst_ctrl.sv
// Burst scheduler in front of the M-PHY TX state machine: activates from HIBERN8,
// runs PWM/HS bursts (switching side through LINE_CFG when needed) and re-enters HIBERN8.
module m_phy_tx_burst_ctrl
    import m_phy_pkg::*;
#(
    parameter int unsigned T_ACTIVE      = 16,
    parameter int unsigned T_HS_PREPARE  = 16,
    parameter int unsigned T_PWM_PREPARE = 16,
    parameter int unsigned LEN_W         = 8,
    parameter int unsigned WAIT_TIMEOUT  = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_hs_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             hib_req_i,
    input  logic             err_clr_i,
    input  logic [1:0]       phy_state_i,
    output logic [1:0]       line_state_o,
    output logic             rct_o,
    output logic             pwm_2_sleep_o,
    output logic             pwm_2_line_cfg_o,
    output logic             line_cfg_2_sleep_o,
    output logic             line_cfg_2_stall_o,
    output logic             hs_2_stall_o,
    output logic             hs_2_line_cfg_o,
    output logic             data_en_o,
    output logic             side_stall_o,
    output logic             busy_o,
    output logic             error_o
);

    ctrl_state_e      state_q, state_d;
    cfg_phase_e       phase_q, phase_d;
    logic             mode_hs_q, mode_hs_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             side_q, side_d;

    logic        tmr_clr, tmr_tc, tmr_to;
    logic [31:0] tmr_term;

    logic [1:0] line;
    logic       data_en;

    function automatic logic [31:0] prep_term(input logic hs);
        return hs ? 32'(T_HS_PREPARE - 1) : 32'(T_PWM_PREPARE - 1);
    endfunction

    m_phy_wait_timer #(
        .Timeout (WAIT_TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (tmr_clr),
        .en_i      (1'b1),
        .term_i    (tmr_term),
        .tc_o      (tmr_tc),
        .timeout_o (tmr_to)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        mode_hs_d = mode_hs_q;
        len_d     = len_q;
        side_d    = side_q;
        tmr_term  = '0;

        unique case (state_q)
            StHib: begin
                if (start_i) state_d = StActivate;
            end
            StActivate: begin
                tmr_term = 32'(T_ACTIVE + 1);
                if (tmr_tc) begin
                    state_d = StIdle;
                    side_d  = 1'b1;
                end
            end
            StIdle: begin
                if (hib_req_i) begin
                    state_d = StHibEnter;
                end else if (req_valid_i) begin
                    mode_hs_d = req_hs_i;
                    len_d     = req_len_i;
                    if (req_hs_i == side_q) begin
                        state_d = StPrepare;
                    end else begin
                        state_d = StCfgExit;
                        phase_d = PhPrep;
                    end
                end
            end
            // Leave the parked side through a burst of that side, then hand over to LINE_CFG.
            StCfgExit: begin
                unique case (phase_q)
                    PhPrep: begin
                        tmr_term = prep_term(side_q);
                        if (tmr_tc) phase_d = PhWait;
                    end
                    PhWait: begin
                        if (phy_state_i == burst_code(side_q)) phase_d = PhStrobe;
                        else if (tmr_to) state_d = StError;
                    end
                    default: begin
                        state_d = StCfgEnter;
                        phase_d = PhWait;
                    end
                endcase
            end
            StCfgEnter: begin
                unique case (phase_q)
                    PhWait: begin
                        if (phy_state_i == PS_CFG) phase_d = PhStrobe;
                        else if (tmr_to) state_d = StError;
                    end
                    PhStrobe: begin
                        phase_d = PhSettle;
                    end
                    default: begin
                        if (phy_state_i == PS_OTHER) begin
                            side_d  = mode_hs_q;
                            state_d = StPrepare;
                        end else if (tmr_to) begin
                            state_d = StError;
                        end
                    end
                endcase
            end
            StPrepare: begin
                tmr_term = prep_term(mode_hs_q);
                if (tmr_tc) state_d = StConfirm;
            end
            StConfirm: begin
                if (phy_state_i == burst_code(mode_hs_q)) state_d = StBurst;
                else if (tmr_to) state_d = StError;
            end
            StBurst: begin
                tmr_term = 32'(len_q);
                if (tmr_tc) state_d = StExit;
            end
            StExit: begin
                state_d = StPark;
            end
            StPark: begin
                if (phy_state_i == PS_OTHER) state_d = StIdle;
                else if (tmr_to) state_d = StError;
            end
            StHibEnter: begin
                state_d = StHib;
            end
            StError: begin
                if (err_clr_i) state_d = StHib;
            end
            default: begin
                state_d = StHib;
            end
        endcase

        tmr_clr = (state_d != state_q) || (phase_d != phase_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StHib;
            phase_q   <= PhPrep;
            mode_hs_q <= 1'b0;
            len_q     <= '0;
            side_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            mode_hs_q <= mode_hs_d;
            len_q     <= len_d;
            side_q    <= side_d;
        end
    end

    always_comb begin
        line               = DIF_N;
        data_en            = 1'b0;
        req_ready_o        = 1'b0;
        error_o            = 1'b0;
        rct_o              = 1'b0;
        pwm_2_sleep_o      = 1'b0;
        pwm_2_line_cfg_o   = 1'b0;
        line_cfg_2_sleep_o = 1'b0;
        line_cfg_2_stall_o = 1'b0;
        hs_2_stall_o       = 1'b0;
        hs_2_line_cfg_o    = 1'b0;

        unique case (state_q)
            StHib: line = DIF_Z;
            StIdle: req_ready_o = 1'b1;
            StCfgExit: begin
                line = DIF_P;
                if (phase_q == PhStrobe) begin
                    hs_2_line_cfg_o  = side_q;
                    pwm_2_line_cfg_o = !side_q;
                end
            end
            StCfgEnter: begin
                line = (phase_q == PhSettle) ? DIF_N : DIF_P;
                if (phase_q == PhStrobe) begin
                    line_cfg_2_stall_o = mode_hs_q;
                    line_cfg_2_sleep_o = !mode_hs_q;
                end
            end
            StPrepare, StConfirm: line = DIF_P;
            StBurst: begin
                line    = DIF_P;
                data_en = 1'b1;
            end
            StExit: begin
                hs_2_stall_o  = mode_hs_q;
                pwm_2_sleep_o = !mode_hs_q;
            end
            StHibEnter: rct_o = 1'b1;
            StError: error_o = 1'b1;
            default: line = DIF_N;
        endcase
    end

    // Reset gates the lane directly so the datapath releases without waiting on state.
    assign line_state_o = rst_ni ? line : DIF_Z;
    assign data_en_o    = rst_ni & data_en;
    assign side_stall_o = side_q;
    assign busy_o       = (state_q != StIdle);

endmodule
